// File: rtl/interrupt_controller.sv
// Latches, masks and prioritises NUM_SRC interrupt lines plus an interval timer; irq_out/irq_any lag PENDING by one clk.
// reg_rdata loads one clk after a clk_en read and holds; no backpressure, every clk_en access completes.
module interrupt_controller #(
  parameter int NUM_SRC     = 16,
  parameter int TIMER_SRC   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NUM_SRC-1:0] src,
  input  logic [2:0]         reg_addr,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  input  logic               ack_valid,
  input  logic [3:0]         ack_id,
  output logic [NUM_SRC-1:0] irq_out,
  output logic               irq_any
);

  localparam logic [2:0] A_PENDING     = 3'd0;
  localparam logic [2:0] A_MASK        = 3'd1;
  localparam logic [2:0] A_EDGE_SEL    = 3'd2;
  localparam logic [2:0] A_TIMER_LOAD  = 3'd3;
  localparam logic [2:0] A_TIMER_COUNT = 3'd4;
  localparam logic [2:0] A_TIMER_CTRL  = 3'd5;
  localparam logic [2:0] A_HIGHEST     = 3'd6;
  localparam logic [2:0] A_SW_SET      = 3'd7;
  localparam int         PAD           = 32 - NUM_SRC;

  typedef enum logic {T_IDLE, T_RUN} timer_state_t;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] src_lvl, src_prev, src_rise, edge_cap;
  logic [NUM_SRC-1:0] pending, mask, edge_sel, pend_set, pend_clr, pend_masked, wdata_src;
  logic [31:0]        timer_load, timer_count, rd_val;
  logic               timer_en, timer_per, timer_evt, wr_en, rd_en, ctrl_wr, hi_vld;
  logic [3:0]         hi_idx;
  timer_state_t       timer_state;

  assign src_lvl     = sync_q[SYNC_STAGES-1];
  assign src_rise    = src_lvl & ~src_prev;
  assign wr_en       = clk_en & reg_we;
  assign rd_en       = clk_en & reg_re;
  assign ctrl_wr     = wr_en && (reg_addr == A_TIMER_CTRL);
  assign wdata_src   = reg_wdata[NUM_SRC-1:0];
  assign pend_masked = pending & mask;
  // A CTRL write in the same cycle takes priority over an expiry.
  assign timer_evt   = clk_en && !ctrl_wr && (timer_state == T_RUN) && (timer_count == 32'd1);

  // Synchroniser and edge capture run every clk so edges between clk_en pulses are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      src_prev <= '0;
      edge_cap <= '0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      src_prev <= src_lvl;
      edge_cap <= clk_en ? '0 : (edge_cap | src_rise);
    end
  end

  always_comb begin
    pend_clr = '0;
    pend_set = (edge_sel & (edge_cap | src_rise)) | (~edge_sel & src_lvl);
    if (wr_en && reg_addr == A_PENDING) pend_clr = wdata_src;
    if (ack_valid) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (ack_id == 4'(i)) pend_clr[i] = 1'b1;
    end
    if (timer_evt) pend_set[TIMER_SRC] = 1'b1;
    if (wr_en && reg_addr == A_SW_SET) pend_set = pend_set | wdata_src;
  end

  always_comb begin
    hi_vld = |pend_masked;
    hi_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend_masked[i]) hi_idx = 4'(i);
  end

  always_comb begin
    rd_val = 32'd0;
    case (reg_addr)
      A_PENDING:     rd_val = {{PAD{1'b0}}, pending};
      A_MASK:        rd_val = {{PAD{1'b0}}, mask};
      A_EDGE_SEL:    rd_val = {{PAD{1'b0}}, edge_sel};
      A_TIMER_LOAD:  rd_val = timer_load;
      A_TIMER_COUNT: rd_val = timer_count;
      A_TIMER_CTRL:  rd_val = {30'd0, timer_per, timer_en};
      A_HIGHEST:     rd_val = {hi_vld, 27'd0, hi_idx};
      default:       rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      mask        <= '0;
      edge_sel    <= '0;
      timer_load  <= 32'd0;
      timer_count <= 32'd0;
      timer_en    <= 1'b0;
      timer_per   <= 1'b0;
      timer_state <= T_IDLE;
      reg_rdata   <= 32'd0;
      irq_out     <= '0;
      irq_any     <= 1'b0;
    end else begin
      irq_out <= pend_masked;
      irq_any <= hi_vld;
      if (clk_en) begin
        pending <= (pending & ~pend_clr) | pend_set;
        if (rd_en) reg_rdata <= rd_val;
        if (wr_en) begin
          case (reg_addr)
            A_MASK:       mask       <= wdata_src;
            A_EDGE_SEL:   edge_sel   <= wdata_src;
            A_TIMER_LOAD: timer_load <= reg_wdata;
            default: ;
          endcase
        end
        if (ctrl_wr) begin
          timer_en  <= reg_wdata[0];
          timer_per <= reg_wdata[1];
          if (reg_wdata[0] && timer_load != '0) begin
            timer_state <= T_RUN;
            timer_count <= timer_load;
          end else begin
            timer_state <= T_IDLE;
          end
        end else if (timer_state == T_RUN) begin
          if (timer_count == 32'd1) begin
            if (timer_per && timer_load != '0) begin
              timer_count <= timer_load;
            end else begin
              timer_count <= 32'd0;
              timer_en    <= 1'b0;
              timer_state <= T_IDLE;
            end
          end else if (timer_count != '0) begin
            timer_count <= timer_count - 32'd1;
          end else begin
            timer_state <= T_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed feature scenarios followed by randomized traffic, all checked against a register-level reference model.
module tb_interrupt_controller;

  logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic [15:0] src = '0;
  logic [2:0]  reg_addr = '0;
  logic        reg_we = 1'b0, reg_re = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        ack_valid = 1'b0;
  logic [3:0]  ack_id = '0;
  logic [15:0] irq_out;
  logic        irq_any;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] tb_src = '0;

  // Reference model state: architectural registers as plain variables.
  logic [15:0] m_pend, m_mask, m_edge, m_prev;
  logic [31:0] m_load, m_count, m_rdata;
  bit          m_en, m_per, m_run;

  interrupt_controller #(.NUM_SRC(16), .TIMER_SRC(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .src(src),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_re(reg_re), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .ack_valid(ack_valid), .ack_id(ack_id),
    .irq_out(irq_out), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
    m_load = '0; m_count = '0; m_rdata = '0;
    m_en = 0; m_per = 0; m_run = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    logic [15:0] pm;
    bit found;
    r = '0; found = 0; pm = m_pend & m_mask;
    case (a)
      3'd0: r = {16'd0, m_pend};
      3'd1: r = {16'd0, m_mask};
      3'd2: r = {16'd0, m_edge};
      3'd3: r = m_load;
      3'd4: r = m_count;
      3'd5: r = {30'd0, m_per, m_en};
      3'd6: for (int i = 0; i < 16; i++)
              if (!found && pm[i]) begin r = 32'h8000_0000 | 32'(i); found = 1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_step(input logic [15:0] s, input logic we, input logic re,
                                     input logic [2:0] a, input logic [31:0] wd,
                                     input logic av, input logic [3:0] aid);
    logic [15:0] set, clr;
    set = '0; clr = '0;
    if (re) m_rdata = model_read(a);
    for (int i = 0; i < 16; i++)
      set[i] = m_edge[i] ? (s[i] && !m_prev[i]) : s[i];
    m_prev = s;
    if (we && a == 3'd5) begin
      m_en = wd[0]; m_per = wd[1];
      m_run = m_en && (m_load != 0);
      if (m_run) m_count = m_load;
    end else if (m_run) begin
      if (m_count == 1) begin
        set[0] = 1'b1;
        if (m_per && m_load != 0) m_count = m_load;
        else begin m_count = 0; m_en = 0; m_run = 0; end
      end else m_count = m_count - 1;
    end
    if (we) case (a)
      3'd0: clr = wd[15:0];
      3'd1: m_mask = wd[15:0];
      3'd2: m_edge = wd[15:0];
      3'd3: m_load = wd;
      3'd7: set = set | wd[15:0];
      default: ;
    endcase
    if (av) clr[aid] = 1'b1;
    m_pend = (m_pend & ~clr) | set;
  endfunction

  // One clk_en access: src settles for two clks, one enabled clk, then one clk for irq_out to follow.
  task automatic do_step(input logic [15:0] s, input logic we, input logic re, input logic [2:0] a,
                         input logic [31:0] wd, input logic av, input logic [3:0] aid);
    src = s;
    @(negedge clk);
    @(negedge clk);
    clk_en = 1'b1; reg_we = we; reg_re = re; reg_addr = a; reg_wdata = wd;
    ack_valid = av; ack_id = aid;
    @(negedge clk);
    clk_en = 1'b0; reg_we = 1'b0; reg_re = 1'b0; ack_valid = 1'b0;
    @(negedge clk);
    model_step(s, we, re, a, wd, av, aid);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    do_step(tb_src, 1'b1, 1'b0, a, d, 1'b0, 4'd0);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    do_step(tb_src, 1'b0, 1'b1, a, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    if (irq_out !== 16'h0) begin n_bad++; $display("FAIL reset_irq: got %h want 0000", irq_out); end
    n_cmp++;
    if (irq_any !== 1'b0) begin n_bad++; $display("FAIL reset_any: got %b want 0", irq_any); end
    n_cmp++;
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", reg_rdata); end
    n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    rd_reg(3'd0);
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", reg_rdata); end
    n_cmp++;
    rd_reg(3'd5);
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", reg_rdata); end
    n_cmp++;
  endtask

  task automatic test_edge_source();
    wr_reg(3'd1, 32'h4);
    wr_reg(3'd2, 32'h4);
    // One-clk pulse on src[2] between enable pulses (divider 3).
    src = 16'h4;
    @(negedge clk); src = 16'h0;
    @(negedge clk); clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
    m_pend[2] = 1'b1;
    if (irq_out !== 16'h0) begin n_bad++; $display("FAIL edge_irq_lag: got %h want 0000", irq_out); end
    n_cmp++;
    @(negedge clk);
    if (irq_out !== 16'h4) begin n_bad++; $display("FAIL edge_irq: got %h want 0004", irq_out); end
    n_cmp++;
    rd_reg(3'd0);
    if (reg_rdata !== 32'h4) begin n_bad++; $display("FAIL edge_pending: got %h want 4", reg_rdata); end
    n_cmp++;
    rd_reg(3'd6);
    if (reg_rdata !== 32'h8000_0002) begin n_bad++; $display("FAIL edge_highest: got %h want 80000002", reg_rdata); end
    n_cmp++;
  endtask

  task automatic test_ack_and_sticky();
    do_step(16'h0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 4'd2);
    if (irq_out !== 16'h0 || irq_any !== 1'b0) begin
      n_bad++; $display("FAIL ack_clear: got %h/%b want 0000/0", irq_out, irq_any);
    end
    n_cmp++;
    // Edge lands on a clk_en=0 cycle and must survive until the next enable.
    src = 16'h4; clk_en = 1'b1;
    @(negedge clk); src = 16'h0; clk_en = 1'b0;
    repeat (4) @(negedge clk);
    if (irq_out !== 16'h0) begin n_bad++; $display("FAIL sticky_wait: got %h want 0000", irq_out); end
    n_cmp++;
    clk_en = 1'b1;
    @(negedge clk); clk_en = 1'b0;
    @(negedge clk);
    m_pend[2] = 1'b1;
    if (irq_out !== 16'h4) begin n_bad++; $display("FAIL sticky_irq: got %h want 0004", irq_out); end
    n_cmp++;
    do_step(16'h0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 4'd2);
    // Level source held high re-pends in the same cycle it is acknowledged.
    wr_reg(3'd2, 32'h0);
    tb_src = 16'h4;
    do_step(tb_src, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 4'd0);
    do_step(tb_src, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 4'd2);
    rd_reg(3'd0);
    if (reg_rdata !== 32'h4) begin n_bad++; $display("FAIL level_reack: got %h want 4", reg_rdata); end
    n_cmp++;
    tb_src = 16'h0;
    wr_reg(3'd0, 32'hFFFF);
  endtask

  task automatic test_priority_mask();
    wr_reg(3'd7, 32'hABCD_0030);
    wr_reg(3'd1, 32'h20);
    if (irq_out !== 16'h20 || irq_any !== 1'b1) begin
      n_bad++; $display("FAIL prio_irq: got %h/%b want 0020/1", irq_out, irq_any);
    end
    n_cmp++;
    rd_reg(3'd6);
    if (reg_rdata !== 32'h8000_0005) begin n_bad++; $display("FAIL prio_highest: got %h want 80000005", reg_rdata); end
    n_cmp++;
    wr_reg(3'd0, 32'h10);
    rd_reg(3'd0);
    if (reg_rdata !== 32'h20) begin n_bad++; $display("FAIL prio_w1c: got %h want 20", reg_rdata); end
    n_cmp++;
    wr_reg(3'd0, 32'hFFFF);
  endtask

  task automatic test_periodic_timer();
    wr_reg(3'd1, 32'h1);
    wr_reg(3'd3, 32'd5);
    wr_reg(3'd5, 32'h3);
    // W1C every cycle: bit 0 only survives where the expiry coincides with the clear.
    for (int k = 1; k <= 15; k++) begin
      wr_reg(3'd0, 32'h1);
      if (irq_out[0] !== (k % 5 == 0)) begin
        n_bad++; $display("FAIL periodic_k%0d: got %b want %b", k, irq_out[0], (k % 5 == 0));
      end
      n_cmp++;
    end
    wr_reg(3'd5, 32'h0);
  endtask

  task automatic test_oneshot_timer();
    wr_reg(3'd3, 32'd3);
    wr_reg(3'd5, 32'h1);
    for (int k = 1; k <= 23; k++) begin
      wr_reg(3'd0, 32'h1);
      if (irq_out[0] !== (k == 3)) begin
        n_bad++; $display("FAIL oneshot_k%0d: got %b want %b", k, irq_out[0], (k == 3));
      end
      n_cmp++;
    end
    rd_reg(3'd5);
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL oneshot_ctrl: got %h want 0", reg_rdata); end
    n_cmp++;
    rd_reg(3'd4);
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL oneshot_count: got %h want 0", reg_rdata); end
    n_cmp++;
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd5, 32'h1);
    for (int k = 0; k < 5; k++) begin
      wr_reg(3'd0, 32'h1);
      if (irq_out[0] !== 1'b0) begin n_bad++; $display("FAIL zero_load_k%0d: got %b want 0", k, irq_out[0]); end
      n_cmp++;
    end
    rd_reg(3'd5);
    if (reg_rdata !== 32'h1) begin n_bad++; $display("FAIL zero_load_ctrl: got %h want 1", reg_rdata); end
    n_cmp++;
    wr_reg(3'd5, 32'h0);
  endtask

  task automatic test_async_reset();
    wr_reg(3'd1, 32'hFFFF);
    wr_reg(3'd3, 32'd4);
    wr_reg(3'd5, 32'h1);
    wr_reg(3'd7, 32'hFFFF);
    rd_reg(3'd4);
    if (irq_out !== 16'hFFFF || reg_rdata !== 32'd3) begin
      n_bad++; $display("FAIL prereset: got %h/%h want ffff/3", irq_out, reg_rdata);
    end
    n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if (irq_out !== 16'h0 || irq_any !== 1'b0 || reg_rdata !== 32'h0) begin
      n_bad++; $display("FAIL arst_outputs: got %h/%b/%h want 0000/0/0", irq_out, irq_any, reg_rdata);
    end
    n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    model_reset(); tb_src = '0;
    wr_reg(3'd1, 32'hFFFF);
    for (int k = 0; k < 6; k++) begin
      do_step(tb_src, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 4'd0);
      if (irq_out !== 16'h0) begin n_bad++; $display("FAIL arst_noevt_k%0d: got %h want 0000", k, irq_out); end
      n_cmp++;
    end
    rd_reg(3'd4);
    if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL arst_count: got %h want 0", reg_rdata); end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [15:0] s;
    logic [2:0]  a;
    logic [31:0] wd;
    logic        we, re, av;
    logic [3:0]  aid;
    for (int n = 0; n < 400; n++) begin
      s   = tb_src ^ 16'($urandom & $urandom & $urandom);
      a   = 3'($urandom_range(0, 7));
      we  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 1) == 1);
      case (a)
        3'd3:       wd = 32'($urandom_range(1, 7));
        3'd0, 3'd7: wd = $urandom & $urandom;
        default:    wd = $urandom;
      endcase
      av  = ($urandom_range(0, 3) == 0);
      aid = 4'($urandom);
      tb_src = s;
      do_step(s, we, re, a, wd, av, aid);
      if (irq_out !== (m_pend & m_mask)) begin
        n_bad++; $display("FAIL rand_irq_%0d: got %h want %h", n, irq_out, m_pend & m_mask);
      end
      n_cmp++;
      if (irq_any !== |(m_pend & m_mask)) begin
        n_bad++; $display("FAIL rand_any_%0d: got %b want %b", n, irq_any, |(m_pend & m_mask));
      end
      n_cmp++;
      if (reg_rdata !== m_rdata) begin
        n_bad++; $display("FAIL rand_rdata_%0d: got %h want %h", n, reg_rdata, m_rdata);
      end
      n_cmp++;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_edge_source();
    test_ack_and_sticky();
    test_priority_mask();
    test_periodic_timer();
    test_oneshot_timer();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
